uart_rx_byte: RTL

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte_if.sv | 24 ++
 rtl/rx_sync.sv | 27 ++
 rtl/uart_rx_byte.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and baud-rate helpers for the UART byte receiver.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
`ifdef UART_RX_PARITY_EN
    StPar   = 3'd3,
`endif
    StStop  = 3'd4
  } rx_state_e;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Cycles from the start-bit edge to its mid-point, truncated.
  function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial line in, received byte and status pulses out.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] data;
  logic       data_vld;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rx,
    output data,
    output data_vld,
    output frame_err,
    output busy
  );

  modport master (
    output rx,
    input  data,
    input  data_vld,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module rx_sync #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking.
// Samples each bit at its mid-point and returns to idle at the stop-bit mid-point.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic           sys_clk,
  input  logic           rst,
  uart_rx_byte_if.slave  bus
);

  localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF     = calc_half(CLK_HZ, BAUD);
  localparam int unsigned CntW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DivLast  = (DIV > 0) ? DIV - 1 : 0;
  localparam int unsigned HalfLast = (HALF > 0) ? HALF - 1 : 0;

  logic            rxs;
  logic            rxs_prev_q, rxs_prev_d;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            data_vld_q, data_vld_d;
  logic            frame_err_q, frame_err_d;
  logic            stop_ok;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  rx_sync #(
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk_i (sys_clk),
    .rst_i (rst),
    .d_i   (bus.rx),
    .q_o   (rxs)
  );

`ifdef UART_RX_PARITY_EN
  assign stop_ok = rxs & ~par_err_q;
`else
  assign stop_ok = rxs;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    data_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    rxs_prev_d  = rxs;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (cnt_q == CntW'(HalfLast)) begin
          cnt_d = '0;
          // A start bit that is high again at its mid-point was only a glitch.
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntW'(DivLast)) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StPar;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StPar: begin
        if (cnt_q == CntW'(DivLast)) begin
          cnt_d     = '0;
          par_err_d = rxs ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (cnt_q == CntW'(DivLast)) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (stop_ok) begin
            data_d     = shift_q;
            data_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      data_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rxs_prev_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      data_vld_q  <= data_vld_d;
      frame_err_q <= frame_err_d;
      rxs_prev_q  <= rxs_prev_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.data_vld  = data_vld_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
